ssd_scan_capture: RTL and testbench
===================================

Name: ssd_scan_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment scan driver.
- Samples the active-low anode and cathode lines, decodes each digit's segment pattern back to a hex nibble, and assembles the four nibbles into a 16-bit frame.
- Used in the same clock domain for loopback self-check of SSD output, and as a bench monitor that reads displayed values (Ain/Bin, A/B, GCD/i_count) back as numbers.

Parameters:
- STABLE_CYC, 16: consecutive identical sampled {An,Cath} cycles required before a digit is accepted (must be at least 2).
- TIMEOUT_CYC, 1048576: cycles without any accepted digit before a partial frame is discarded.
- CNT_W, 21: width of the stability and timeout counters; must hold TIMEOUT_CYC.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous, active-low reset.
- An  input  4  anode lines, active-low. An[3] is the leftmost digit (nibble [15:12]); An[0] is the rightmost (nibble [3:0]).
- Cath  input  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.
- Clr_Err  input  1  one-cycle pulse that clears Err.
- Value  output  16  last complete frame, {digit3,digit2,digit1,digit0}.
- Dp_Val  output  4  decimal-point state per digit of the last frame; 1 = lit.
- Valid  output  1  one-cycle pulse when Value/Dp_Val update.
- Changed  output  1  one-cycle pulse, coincident with Valid, when the new Value differs from the previous Value.
- Err  output  3  sticky flags: [0] undecodable pattern, [1] more than one anode active, [2] frame timeout.

Behaviour:
- Reset (Reset_n=0, asynchronous): Value=0, Dp_Val=0, Valid=0, Changed=0, Err=0. The synchronizer flops reset to all-ones (idle). Captured mask, counters and accept flag reset to 0.
- Input path: 2-flop synchronizer on An and Cath. All decisions use the synchronized sample S. Input-to-acceptance latency is 2 + STABLE_CYC cycles.
- Stability counter:
  - If S equals the previous S, the counter increments, saturating at STABLE_CYC.
  - If S differs, the counter resets to 0 and the accept flag clears.
  - A dwell is qualified on the cycle the counter first reaches STABLE_CYC-1 (STABLE_CYC identical samples) with the accept flag clear. The accept flag is then set, so each dwell is acted on at most once.
- Anode classification on a qualified dwell:
  - No An bit low: blank; ignored.
  - Exactly one An bit low: digit index k = position of the low bit.
  - Two or more An bits low: set Err[1]; nothing stored.
- Cathode decode (Cath[7:1] = abcdefg, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
  - On a match: store the nibble in slot k, store dp[k] = ~Cath[0], set mask[k], reset the timeout counter.
  - On no match: set Err[0]; slot and mask are unchanged.
- Overwrite: a slot already captured in the current frame is overwritten by a later acceptance (last value wins).
- Frame completion: in the cycle after mask becomes 4'b1111:
  - Value <= slots, Dp_Val <= dp, Valid=1 for exactly one cycle.
  - Changed=1 if the new Value differs from the old Value. Dp changes alone do not assert Changed.
  - mask is cleared in the same cycle. The first frame after reset asserts Changed if its Value is not 0.
- Timeout:
  - The timeout counter increments whenever mask is not 0. It is held at 0 while mask is 0.
  - On reaching TIMEOUT_CYC: clear mask, set Err[2], reset the counter. Value is unchanged.
- Err: bits are sticky. Clr_Err clears all bits; a set event in the same cycle as Clr_Err wins.
- Simultaneous events: a frame completion and a timeout in the same cycle resolve as completion (no Err[2]).
- Reset mid-frame discards all partial state immediately.

Test Plan (STABLE_CYC=4, TIMEOUT_CYC=64):
- Scan 1,2,3,4 on An=0111/1011/1101/1110, 8-cycle dwell each, with 2-cycle blank gaps (An=1111) -> single Valid with Value=16'h1234, Changed=1, Dp_Val=0, Err=0. A second identical scan -> Valid with Changed=0.
- Dwell shorter than 4 cycles on digit 2 (3 cycles) -> digit not accepted; no Valid until a full-length rescan gives Value=16'hA0F7 for A,0,F,7.
- Cath pattern 8'b11111111 on An=1110 for 8 cycles -> Err=3'b001, no Valid. Clr_Err pulse -> Err=0.
- An=0011 stable for 8 cycles -> Err[1]=1. Capture only digits 3 and 2, then idle 70 cycles -> Err[2]=1, Value unchanged, next full scan restarts cleanly.
- Dp low on digit 0 only, scanning 9,8,C,E -> Value=16'h98CE, Dp_Val=4'b0001.
- Assert Reset_n=0 after 3 digits captured -> all outputs 0 immediately. A full scan after release yields exactly one Valid.

Source files
------------

// File: rtl/ssd_scan_capture.sv
// Receive side of a multiplexed 4-digit seven-segment scan. It samples the
// active-low anode/cathode lines and rebuilds the displayed 16-bit hex value.
module ssd_scan_capture #(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int CNT_W       = 21
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [3:0]  An,
    input  logic [7:0]  Cath,
    input  logic        Clr_Err,
    output logic [15:0] Value,
    output logic [3:0]  Dp_Val,
    output logic        Valid,
    output logic        Changed,
    output logic [2:0]  Err
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] QUAL_CNT   = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [3:0]       an_meta, an_sync;
    logic [7:0]       cath_meta, cath_sync;
    logic [11:0]      samp_prev;
    logic [CNT_W-1:0] stab_cnt, stab_next;
    logic             accepted, accepted_next;
    logic [CNT_W-1:0] tmo_cnt, tmo_next;
    logic [3:0]       mask, mask_next;
    logic [15:0]      slots;
    logic [3:0]       dp;
    logic [2:0]       err_next;

    logic             same, qualify, one_low, multi_low;
    logic [1:0]       dig_idx;
    logic [4:0]       dec;
    logic             accept_digit, bad_pattern, multi_anode;
    logic             complete, timeout;

    // Segment pattern abcdefg (0 = lit) back to {hit, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'h00;
        case (seg)
            7'b0000001: r = 5'h10;
            7'b1001111: r = 5'h11;
            7'b0010010: r = 5'h12;
            7'b0000110: r = 5'h13;
            7'b1001100: r = 5'h14;
            7'b0100100: r = 5'h15;
            7'b0100000: r = 5'h16;
            7'b0001111: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0000100: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b1100000: r = 5'h1B;
            7'b0110001: r = 5'h1C;
            7'b1000010: r = 5'h1D;
            7'b0110000: r = 5'h1E;
            7'b0111000: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        same          = ({an_sync, cath_sync} == samp_prev);
        stab_next     = '0;
        accepted_next = 1'b0;
        one_low       = 1'b0;
        dig_idx       = 2'd0;
        multi_low     = 1'b0;
        dec           = decode_seg(cath_sync[7:1]);

        if (same) begin
            stab_next = (stab_cnt == STABLE_MAX) ? stab_cnt : stab_cnt + CNT_ONE;
        end
        // A dwell is qualified once, when STABLE_CYC identical samples are seen.
        qualify = same && (stab_next == QUAL_CNT) && !accepted;
        if (same) begin
            accepted_next = accepted | qualify;
        end

        case (an_sync)
            4'b1110: begin one_low = 1'b1; dig_idx = 2'd0; end
            4'b1101: begin one_low = 1'b1; dig_idx = 2'd1; end
            4'b1011: begin one_low = 1'b1; dig_idx = 2'd2; end
            4'b0111: begin one_low = 1'b1; dig_idx = 2'd3; end
            4'b1111: multi_low = 1'b0;
            default: multi_low = 1'b1;
        endcase

        accept_digit = qualify && one_low && dec[4];
        bad_pattern  = qualify && one_low && !dec[4];
        multi_anode  = qualify && multi_low;

        complete = (mask == 4'hF);
        timeout  = !complete && (mask != 4'h0) && (tmo_cnt == TMO_MAX);

        mask_next = (complete || timeout) ? 4'h0 : mask;
        if (accept_digit) begin
            mask_next[dig_idx] = 1'b1;
        end

        if (accept_digit || complete || timeout || (mask == 4'h0)) begin
            tmo_next = '0;
        end else begin
            tmo_next = tmo_cnt + CNT_ONE;
        end

        // A flag raised in the same cycle as Clr_Err survives the clear.
        err_next = (Clr_Err ? 3'b000 : Err) | {timeout, multi_anode, bad_pattern};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            an_meta   <= 4'hF;
            an_sync   <= 4'hF;
            cath_meta <= 8'hFF;
            cath_sync <= 8'hFF;
            samp_prev <= 12'hFFF;
            stab_cnt  <= '0;
            accepted  <= 1'b0;
            tmo_cnt   <= '0;
            mask      <= 4'h0;
            slots     <= 16'h0000;
            dp        <= 4'h0;
            Value     <= 16'h0000;
            Dp_Val    <= 4'h0;
            Valid     <= 1'b0;
            Changed   <= 1'b0;
            Err       <= 3'b000;
        end else begin
            an_meta   <= An;
            an_sync   <= an_meta;
            cath_meta <= Cath;
            cath_sync <= cath_meta;
            samp_prev <= {an_sync, cath_sync};
            stab_cnt  <= stab_next;
            accepted  <= accepted_next;
            tmo_cnt   <= tmo_next;
            mask      <= mask_next;
            Err       <= err_next;
            if (accept_digit) begin
                slots[dig_idx*4 +: 4] <= dec[3:0];
                dp[dig_idx]           <= ~cath_sync[0];
            end
            Valid   <= complete;
            Changed <= complete && (slots != Value);
            if (complete) begin
                Value  <= slots;
                Dp_Val <= dp;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Randomized scoreboard bench for ssd_scan_capture: a digit-level model predicts
// frames and error flags; a monitor checks every Valid pulse against the queue.
module tb_ssd_scan_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 64;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  An;
    logic [7:0]  Cath;
    logic        Clr_Err;
    logic [15:0] Value;
    logic [3:0]  Dp_Val;
    logic        Valid;
    logic        Changed;
    logic [2:0]  Err;

    ssd_scan_capture #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO), .CNT_W(21)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .An(An), .Cath(Cath), .Clr_Err(Clr_Err),
        .Value(Value), .Dp_Val(Dp_Val), .Valid(Valid), .Changed(Changed), .Err(Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dp;
        logic        ch;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int pushes = 0;
    int valids = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model of the captured frame: which digits are in, their values, last frame.
    logic [15:0] m_slots;
    logic [3:0]  m_dp;
    logic [3:0]  m_mask;
    logic [15:0] m_last;
    logic [2:0]  m_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_slots = 16'h0; m_dp = 4'h0; m_mask = 4'h0; m_last = 16'h0; m_err = 3'b000;
    endtask

    task automatic model_accept(input logic [3:0] an, input logic [7:0] cath, input int len);
        int k;
        int d;
        if (len < STABLE || an == 4'hF) return;
        if ($countones(an) < 3) begin
            m_err[1] = 1'b1;
            return;
        end
        k = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) k = i;
        d = -1;
        for (int j = 0; j < 16; j++) if (seg_tab[j] == cath[7:1]) d = j;
        if (d < 0) begin
            m_err[0] = 1'b1;
            return;
        end
        m_slots[4*k +: 4] = d[3:0];
        m_dp[k] = ~cath[0];
        m_mask[k] = 1'b1;
        if (m_mask == 4'hF) begin
            sbq.push_back('{v: m_slots, dp: m_dp, ch: (m_slots != m_last)});
            pushes++;
            m_last = m_slots;
            m_mask = 4'h0;
        end
    endtask

    // Hold one pattern for len cycles, then a 2-cycle blank gap.
    task automatic applyStimulus(input logic [3:0] an, input logic [7:0] cath, input int len);
        model_accept(an, cath, len);
        An = an; Cath = cath;
        repeat (len) tick();
        An = 4'hF; Cath = 8'hFF;
        repeat (2) tick();
    endtask

    task automatic scan(input logic [15:0] val, input logic [3:0] dpl, input logic [3:0] short_m);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(~(4'b0001 << i), {seg_tab[val[4*i +: 4]], ~dpl[i]}, short_m[i] ? 3 : 8);
        end
    endtask

    // Idle runs are either short (no timeout) or at least 70 cycles (timeout).
    task automatic idle(input int n);
        if (n >= 70 && m_mask != 4'h0) begin
            m_mask = 4'h0;
            m_err[2] = 1'b1;
        end
        repeat (n) tick();
    endtask

    task automatic pulse_clr();
        Clr_Err = 1'b1;
        tick();
        Clr_Err = 1'b0;
        m_err = 3'b000;
    endtask

    task automatic checkOutput(input string name);
        repeat (4) tick();
        check(name, {29'd0, Err}, {29'd0, m_err});
    endtask

    task automatic hit_reset();
        Reset_n = 1'b0;
        An = 4'hF; Cath = 8'hFF; Clr_Err = 1'b0;
        #1;
        check("rst_value", {16'd0, Value}, 32'd0);
        check("rst_dp", {28'd0, Dp_Val}, 32'd0);
        check("rst_valid", {31'd0, Valid}, 32'd0);
        check("rst_changed", {31'd0, Changed}, 32'd0);
        check("rst_err", {29'd0, Err}, 32'd0);
        check("rst_pending", sbq.size(), 32'd0);
        model_reset();
        tick(); tick();
        Reset_n = 1'b1;
        tick();
    endtask

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (Valid) begin
                valids++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_valid: got Value=%h want no frame at %0t", Value, $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("frame_value", {16'd0, Value}, {16'd0, e.v});
                    check("frame_dp", {28'd0, Dp_Val}, {28'd0, e.dp});
                    check("frame_changed", {31'd0, Changed}, {31'd0, e.ch});
                end
            end else if (Changed) begin
                total++;
                bad++;
                $display("[TB] FAIL changed_without_valid: got 1 want 0 at %0t", $time);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rv;
        logic [3:0]  rdp;
        logic [3:0]  rshort;
        Reset_n = 1'b0; An = 4'hF; Cath = 8'hFF; Clr_Err = 1'b0;
        model_reset();
        #3;
        hit_reset();

        scan(16'h1234, 4'h0, 4'h0);
        checkOutput("err_after_1234");
        scan(16'h1234, 4'h0, 4'h0);
        checkOutput("err_after_repeat");

        scan(16'hA0F7, 4'h0, 4'b0100);
        scan(16'hA0F7, 4'h0, 4'h0);
        checkOutput("err_after_a0f7");

        applyStimulus(4'b1110, 8'hFF, 8);
        checkOutput("err_bad_pattern");
        pulse_clr();
        checkOutput("err_cleared");

        idle(70);
        pulse_clr();
        applyStimulus(4'b0011, {seg_tab[5], 1'b1}, 8);
        checkOutput("err_multi_anode");
        applyStimulus(4'b0111, {seg_tab[6], 1'b1}, 8);
        applyStimulus(4'b1011, {seg_tab[7], 1'b1}, 8);
        idle(70);
        checkOutput("err_timeout");
        check("value_after_timeout", {16'd0, Value}, {16'd0, m_last});
        pulse_clr();
        scan(16'h5A3C, 4'h0, 4'h0);
        checkOutput("err_after_restart");

        scan(16'h98CE, 4'b0001, 4'h0);
        checkOutput("err_after_dp");

        applyStimulus(4'b0111, {seg_tab[3], 1'b1}, 8);
        applyStimulus(4'b1011, {seg_tab[2], 1'b1}, 8);
        applyStimulus(4'b1101, {seg_tab[1], 1'b1}, 8);
        hit_reset();
        scan(16'h4321, 4'h0, 4'h0);
        checkOutput("err_after_midreset");

        for (int f = 0; f < 25; f++) begin
            rv = 16'($urandom);
            rdp = 4'($urandom);
            rshort = ($urandom_range(0, 2) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
            scan(rv, rdp, rshort);
            if ($urandom_range(0, 7) == 0) applyStimulus(~(4'b0001 << $urandom_range(0, 3)), 8'hFF, 8);
            if ($urandom_range(0, 9) == 0) applyStimulus(4'b0101, {seg_tab[1], 1'b1}, 8);
            checkOutput("err_random");
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end
        idle(80);
        checkOutput("err_final");

        idle(10);
        check("pending_frames", sbq.size(), 32'd0);
        check("valid_count", valids, pushes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
